// File: rtl/frame_scanout.sv
// Raster scan-out: walks an 800x525 frame on pix_en strobes and reads pixels from a buffer.
// It registers each pixel's RGB and sync outputs exactly two clocks after that pixel's strobe.
module frame_scanout #(
  parameter int DATA_WIDTH = 12,
  parameter int X_WIDTH    = 10,
  parameter int Y_WIDTH    = 10,
  parameter int ADDR_WIDTH = X_WIDTH + Y_WIDTH,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pix_en,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [ADDR_WIDTH-1:0] out_address,
  output logic [DATA_WIDTH-1:0] rgb,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  active,
  output logic                  frame_start
);

  localparam logic [X_WIDTH-1:0] H_LAST   = X_WIDTH'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [X_WIDTH-1:0] H_ACT    = X_WIDTH'(H_ACTIVE);
  localparam logic [X_WIDTH-1:0] HS_FIRST = X_WIDTH'(H_ACTIVE + H_FP);
  localparam logic [X_WIDTH-1:0] HS_LAST  = X_WIDTH'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [Y_WIDTH-1:0] V_LAST   = Y_WIDTH'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [Y_WIDTH-1:0] V_ACT    = Y_WIDTH'(V_ACTIVE);
  localparam logic [Y_WIDTH-1:0] VS_FIRST = Y_WIDTH'(V_ACTIVE + V_FP);
  localparam logic [Y_WIDTH-1:0] VS_LAST  = Y_WIDTH'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [X_WIDTH-1:0]    r_h_count;
  logic [Y_WIDTH-1:0]    r_v_count;
  logic                  r_en_d, r_act_d, r_hs_d, r_vs_d, r_fs_d;
  logic [DATA_WIDTH-1:0] r_rgb;
  logic                  r_hsync, r_vsync, r_active, r_frame_start;

  logic w_h_wrap, w_v_wrap, w_act, w_hs, w_vs, w_fs;

  assign w_h_wrap = (r_h_count == H_LAST);
  assign w_v_wrap = (r_v_count == V_LAST);
  assign w_act    = (r_h_count < H_ACT) && (r_v_count < V_ACT);
  assign w_hs     = !((r_h_count >= HS_FIRST) && (r_h_count <= HS_LAST));
  assign w_vs     = !((r_v_count >= VS_FIRST) && (r_v_count <= VS_LAST));
  assign w_fs     = (r_h_count == '0) && (r_v_count == '0);

  assign out_address = ADDR_WIDTH'({r_v_count, r_h_count});
  assign rgb         = r_rgb;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign active      = r_active;
  assign frame_start = r_frame_start;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_h_count <= '0;
      r_v_count <= '0;
    end else if (pix_en) begin
      if (w_h_wrap) begin
        r_h_count <= '0;
        r_v_count <= w_v_wrap ? '0 : r_v_count + Y_WIDTH'(1);
      end else begin
        r_h_count <= r_h_count + X_WIDTH'(1);
      end
    end
  end

  // Stage 1 captures the position decode alongside the buffer's address fetch.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_en_d  <= 1'b0;
      r_act_d <= 1'b0;
      r_hs_d  <= 1'b1;
      r_vs_d  <= 1'b1;
      r_fs_d  <= 1'b0;
    end else begin
      r_en_d <= pix_en;
      if (pix_en) begin
        r_act_d <= w_act;
        r_hs_d  <= w_hs;
        r_vs_d  <= w_vs;
        r_fs_d  <= w_fs;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rgb         <= '0;
      r_active      <= 1'b0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= r_en_d & r_fs_d;
      if (r_en_d) begin
        r_rgb    <= r_act_d ? in_data : '0;
        r_active <= r_act_d;
        r_hsync  <= r_hs_d;
        r_vsync  <= r_vs_d;
      end
    end
  end

endmodule

// File: tb/tb_frame_scanout.sv
// Bench for frame_scanout: a default-timing instance plus a shrunken-raster instance,
// both checked against a strobe-count based raster model every clock.
module tb_frame_scanout;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic pix_en = 1'b0;

  logic [19:0] addr0, addr1;
  logic [11:0] din0, din1, rgb0, rgb1;
  logic hs0, hs1, vs0, vs1, act0, act1, fs0, fs1;

  always #5 clock = ~clock;

  frame_scanout dut0 (
    .clock(clock), .reset(reset), .pix_en(pix_en), .in_data(din0),
    .out_address(addr0), .rgb(rgb0), .hsync(hs0), .vsync(vs0),
    .active(act0), .frame_start(fs0)
  );

  frame_scanout #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut1 (
    .clock(clock), .reset(reset), .pix_en(pix_en), .in_data(din1),
    .out_address(addr1), .rgb(rgb1), .hsync(hs1), .vsync(vs1),
    .active(act1), .frame_start(fs1)
  );

  // Frame buffers holding mem[a] = a[11:0], registered one clock after the address.
  always @(posedge clock) begin
    din0 <= addr0[11:0];
    din1 <= addr1[11:0];
  end

  int HA [2] = '{640, 16};
  int HF [2] = '{16, 2};
  int HS [2] = '{96, 4};
  int HB [2] = '{48, 3};
  int VA [2] = '{480, 8};
  int VF [2] = '{10, 2};
  int VS [2] = '{2, 2};
  int VB [2] = '{33, 3};

  int n [2];
  int pend_n [2];
  bit pend_v [2];
  logic [11:0] e_rgb [2];
  logic e_act [2], e_hs [2], e_vs [2], e_fs [2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic pe, input logic rst);
    pix_en = pe;
    reset  = rst;
    @(posedge clock);
    for (int i = 0; i < 2; i++) begin
      int ht, vt, h, v;
      ht = HA[i] + HF[i] + HS[i] + HB[i];
      vt = VA[i] + VF[i] + VS[i] + VB[i];
      if (rst) begin
        n[i] = 0; pend_v[i] = 0;
        e_rgb[i] = '0; e_act[i] = 0; e_hs[i] = 1; e_vs[i] = 1; e_fs[i] = 0;
      end else begin
        e_fs[i] = 0;
        if (pend_v[i]) begin
          h = pend_n[i] % ht;
          v = pend_n[i] / ht;
          e_act[i] = (h < HA[i]) && (v < VA[i]);
          e_rgb[i] = e_act[i] ? 12'(((v << 10) | h) & 32'hFFF) : 12'h000;
          e_hs[i]  = !((h >= HA[i] + HF[i]) && (h < HA[i] + HF[i] + HS[i]));
          e_vs[i]  = !((v >= VA[i] + VF[i]) && (v < VA[i] + VF[i] + VS[i]));
          e_fs[i]  = (pend_n[i] == 0);
        end
        pend_v[i] = pe;
        if (pe) begin
          pend_n[i] = n[i];
          n[i] = (n[i] + 1) % (ht * vt);
        end
      end
    end
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      int ht, h, v;
      ht = HA[i] + HF[i] + HS[i] + HB[i];
      h = n[i] % ht;
      v = n[i] / ht;
      chk($sformatf("d%0d.addr", i), (i == 0) ? 32'(addr0) : 32'(addr1), 32'((v << 10) | h));
      chk($sformatf("d%0d.rgb", i), (i == 0) ? 32'(rgb0) : 32'(rgb1), 32'(e_rgb[i]));
      chk($sformatf("d%0d.active", i), (i == 0) ? 32'(act0) : 32'(act1), 32'(e_act[i]));
      chk($sformatf("d%0d.hsync", i), (i == 0) ? 32'(hs0) : 32'(hs1), 32'(e_hs[i]));
      chk($sformatf("d%0d.vsync", i), (i == 0) ? 32'(vs0) : 32'(vs1), 32'(e_vs[i]));
      chk($sformatf("d%0d.frame_start", i), (i == 0) ? 32'(fs0) : 32'(fs1), 32'(e_fs[i]));
    end
  endtask

  initial begin
    int hs_low0, act_cnt0, vs_low1, hs_low1, act_cnt1, fs_cnt1, fs_first, fs_second;

    // Reset, then strobes every 4th clock.
    repeat (3) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("first.rgb", 32'(rgb0), 32'h000);
    chk("first.active", 32'(act0), 32'd1);
    chk("first.frame_start", 32'(fs0), 32'd1);
    chk("first.hsync", 32'(hs0), 32'd1);
    chk("first.vsync", 32'(vs0), 32'd1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    repeat (10) begin
      step(1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b0);
    end

    // Continuous strobes: one full default line, two full small frames.
    step(1'b0, 1'b1);
    hs_low0 = 0; act_cnt0 = 0; vs_low1 = 0; hs_low1 = 0; act_cnt1 = 0;
    fs_cnt1 = 0; fs_first = -1; fs_second = -1;
    for (int k = 1; k <= 802; k++) begin
      step(1'b1, 1'b0);
      if (k >= 2 && k <= 801) begin
        if (!hs0) hs_low0++;
        if (act0) act_cnt0++;
      end
      if (k >= 2 && k <= 376) begin
        if (!vs1) vs_low1++;
        if (!hs1) hs_low1++;
        if (act1) act_cnt1++;
        if (fs1) fs_cnt1++;
      end
      if (fs1 && fs_first < 0) fs_first = k;
      else if (fs1 && fs_second < 0) fs_second = k;
    end
    chk("line.hsync_low", 32'(hs_low0), 32'd96);
    chk("line.active_cnt", 32'(act_cnt0), 32'd640);
    chk("frame.vsync_low", 32'(vs_low1), 32'd50);
    chk("frame.hsync_low", 32'(hs_low1), 32'd60);
    chk("frame.active_cnt", 32'(act_cnt1), 32'd128);
    chk("frame.fs_cnt", 32'(fs_cnt1), 32'd1);
    chk("frame.fs_period", 32'(fs_second - fs_first), 32'd375);

    // Mid-frame reset (small raster at h=10, v=5), asserted together with pix_en.
    step(1'b0, 1'b1);
    repeat (135) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("midrst.addr", 32'(addr1), 32'd0);
    chk("midrst.active", 32'(act1), 32'd0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("midrst.restart_fs", 32'(fs1), 32'd1);

    // Last position of the small frame strobed, with idle clocks around the wrap.
    step(1'b0, 1'b1);
    repeat (374) step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("wrap.addr", 32'(addr1), 32'd0);
    repeat (3) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("wrap.fs", 32'(fs1), 32'd1);

    // Random strobe gaps of 0-7 clocks.
    repeat (1500) begin
      step(1'b1, 1'b0);
      repeat ($urandom_range(0, 7)) step(1'b0, 1'b0);
    end
    repeat (3) step(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
